// File: rtl/spike_buffer_if.sv
// ---------------------------------------------------------------------------
// spike_buffer_if
// Handshake and memory-control bundle between the spike buffer access
// controller and its environment (router input, neuron-core output,
// clock-gating cell and memory address pins).
//   flush       : synchronous clear request (environment -> controller)
//   in_valid    : router presents a spike word
//   in_ready    : controller can accept a word
//   out_valid   : memory output register holds the head word
//   out_ready   : neuron core consumes the head word
//   en_w, en_r  : write/read clock enables for the clock-gating cell
//   waddr, raddr: memory write/read addresses
//   count       : words held in memory (output register excluded)
//   almost_full : count at or above the configured threshold
// master = environment side, slave = controller side.
// ---------------------------------------------------------------------------
interface spike_buffer_if #(
  parameter int ADDR_W = 4
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic              en_w;
  logic              en_r;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W:0]   count;
  logic              almost_full;

  modport master (
    output flush, in_valid, out_ready,
    input  in_ready, out_valid, en_w, en_r, waddr, raddr, count, almost_full
  );

  modport slave (
    input  flush, in_valid, out_ready,
    output in_ready, out_valid, en_w, en_r, waddr, raddr, count, almost_full
  );
endinterface

// File: rtl/spike_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// spike_buffer_ctrl
// Pointer, occupancy and enable-timing controller for the per-node spike
// buffer. The memory array, its output register and the clock-gating cell
// are external; this block drives their enables and addresses.
// Ports:
//   clk   : single clock (negedge flops used only for en_w/en_r)
//   rst_n : asynchronous active-low reset
//   bus   : spike_buffer_if.slave (handshakes, enables, addresses, status)
// ---------------------------------------------------------------------------
module spike_buffer_ctrl #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int AFULL_TH = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  spike_buffer_if.slave bus
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } ostate_t;

  localparam logic [ADDR_W:0] PTR_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] DEPTH_V  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AFULL_V  = AFULL_TH[ADDR_W:0];

  logic [ADDR_W:0] r_wptr;
  logic [ADDR_W:0] r_rptr;
  ostate_t         r_state;
  ostate_t         w_state_nxt;
  logic            r_en_w;
  logic            r_en_r;

  logic [ADDR_W:0] w_count;
  logic            w_full;
  logic            w_mem_empty;
  logic            w_in_ready;
  logic            w_wf;
  logic            w_ff;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign w_count     = r_wptr - r_rptr;
  assign w_full      = (w_count == DEPTH_V);
  assign w_mem_empty = (w_count == PTR_ZERO);

  // in_ready is forced low during reset so no handshake completes while
  // the gated clocks are stopped.
  assign w_in_ready = !w_full && !bus.flush && rst_n;
  assign w_wf       = bus.in_valid && w_in_ready;

  // Fetch refills the output register when it is empty or being drained.
  assign w_ff = !w_mem_empty && ((r_state == ST_EMPTY) || bus.out_ready) && !bus.flush;

  // Output-stage next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_ff) begin
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready && !w_ff) begin
            w_state_nxt = ST_EMPTY;
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Output-stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Write/read pointers; flush clears both ahead of any traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= PTR_ZERO;
      r_rptr <= PTR_ZERO;
    end else if (bus.flush) begin
      r_wptr <= PTR_ZERO;
      r_rptr <= PTR_ZERO;
    end else begin
      if (w_wf) begin
        r_wptr <= r_wptr + PTR_ONE;
      end else begin
        r_wptr <= r_wptr;
      end
      if (w_ff) begin
        r_rptr <= r_rptr + PTR_ONE;
      end else begin
        r_rptr <= r_rptr;
      end
    end
  end

  // Gating enables captured on the falling edge so they are stable for
  // the whole following high phase (glitch-free AND-type gated clocks).
  // The memory then clocks at the next rising edge using the
  // pre-increment address.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_w <= 1'b0;
      r_en_r <= 1'b0;
    end else begin
      r_en_w <= w_wf;
      r_en_r <= w_ff;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = (r_state == ST_HOLD);
  assign bus.en_w        = r_en_w;
  assign bus.en_r        = r_en_r;
  assign bus.waddr       = r_wptr[ADDR_W-1:0];
  assign bus.raddr       = r_rptr[ADDR_W-1:0];
  assign bus.count       = w_count;
  assign bus.almost_full = (w_count >= AFULL_V);

endmodule

// File: tb/tb_spike_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spike_buffer_ctrl
// Randomised and directed stimulus against a queue-based reference model.
// The bench also models the external memory array and output register,
// clocked from the gated clocks formed with en_w/en_r.
// ---------------------------------------------------------------------------
module tb_spike_buffer_ctrl;
  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int AFULL_TH = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wdata;
  logic [7:0] dout;
  logic [7:0] mem [DEPTH];

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: words in memory, output-register state, and totals.
  int         m_cnt  = 0;
  int         m_ov   = 0;
  int         m_wcnt = 0;
  int         m_rcnt = 0;
  logic [7:0] sb_q [$];

  spike_buffer_if #(.ADDR_W(ADDR_W)) bus ();

  spike_buffer_ctrl #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .AFULL_TH(AFULL_TH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // External memory driven by the gated clocks.
  wire gclk_w = clk & bus.en_w;
  wire gclk_r = clk & bus.en_r;

  always @(posedge gclk_w) mem[bus.waddr] <= wdata;
  always @(posedge gclk_r) dout <= mem[bus.raddr];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [7:0] d);
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    bus.flush     = fl;
    wdata         = d;
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on every output handshake.
  initial begin : mon
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("pop_without_expected_word", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("dout", int'(dout), int'(e));
        end
      end
    end
  end

  // Cycle model: evaluated just before each rising edge.
  initial begin : model
    int  e_rdy;
    int  e_wf;
    int  e_ff;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_en_w", int'(bus.en_w), 0);
        chk("rst_en_r", int'(bus.en_r), 0);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_almost_full", int'(bus.almost_full), 0);
        m_cnt = 0; m_ov = 0; m_wcnt = 0; m_rcnt = 0;
        sb_q.delete();
      end else begin
        e_rdy = ((m_cnt < DEPTH) && !bus.flush) ? 1 : 0;
        e_wf  = (bus.in_valid && (e_rdy == 1)) ? 1 : 0;
        e_ff  = ((m_cnt > 0) && ((m_ov == 0) || bus.out_ready) && !bus.flush) ? 1 : 0;
        chk("in_ready", int'(bus.in_ready), e_rdy);
        chk("count", int'(bus.count), m_cnt);
        chk("out_valid", int'(bus.out_valid), m_ov);
        chk("almost_full", int'(bus.almost_full), (m_cnt >= AFULL_TH) ? 1 : 0);
        chk("en_w", int'(bus.en_w), e_wf);
        chk("en_r", int'(bus.en_r), e_ff);
        chk("waddr", int'(bus.waddr), m_wcnt % DEPTH);
        chk("raddr", int'(bus.raddr), m_rcnt % DEPTH);
        if (bus.flush) begin
          m_cnt = 0; m_ov = 0; m_wcnt = 0; m_rcnt = 0;
          sb_q.delete();
        end else begin
          if (e_wf == 1) begin
            sb_q.push_back(wdata);
            m_wcnt++;
            m_cnt++;
          end
          if (e_ff == 1) begin
            m_rcnt++;
            m_cnt--;
            m_ov = 1;
          end else if ((m_ov == 1) && bus.out_ready) begin
            m_ov = 0;
          end
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    wdata         = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single word through an empty buffer.
    drive(1'b1, 1'b1, 1'b0, 8'hA5);
    repeat (4) drive(1'b0, 1'b1, 1'b0, 8'h00);

    // Fill to full with the consumer stalled, then one pop and drain.
    for (int i = 0; i < 18; i++) drive(1'b1, 1'b0, 1'b0, 8'(i + 16));
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (20) drive(1'b0, 1'b1, 1'b0, 8'h00);

    // Continuous streaming across two pointer wraps.
    for (int i = 0; i < 40; i++) drive(1'b1, 1'b1, 1'b0, 8'(i));
    repeat (5) drive(1'b0, 1'b1, 1'b0, 8'h00);

    // Flush with five words in memory and the output register loaded.
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0, 8'(100 + i));
    drive(1'b1, 1'b0, 1'b1, 8'hFF);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("flush_waddr", int'(bus.waddr), 0);
    chk("flush_raddr", int'(bus.raddr), 0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 1) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
            8'($urandom));
    end
    repeat (20) drive(1'b0, 1'b1, 1'b0, 8'h00);

    // Asynchronous reset in the middle of a high phase while streaming.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 8'(200 + i));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_en_w", int'(bus.en_w), 0);
    chk("midrst_en_r", int'(bus.en_r), 0);
    chk("midrst_count", int'(bus.count), 0);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 8'h5A);
    repeat (5) drive(1'b0, 1'b1, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
